// File: rtl/gamma_parity_frame_if.sv
// Handshake/bus bundle between the gamma unit and the frame parity block.
interface gamma_parity_frame_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 2
);
  logic                 in_valid;
  logic                 sof;
  logic                 odd_mode;
  logic [LANES*W-1:0]   gamma;
  logic                 par_valid;
  logic [LANES-1:0]     par;
  logic                 frame_valid;
  logic [LANES-1:0]     frame_par;
  logic                 frame_err;
  logic                 busy;

  // Producer side: drives samples, observes parity results.
  modport master (
    output in_valid, sof, odd_mode, gamma,
    input  par_valid, par, frame_valid, frame_par, frame_err, busy
  );

  // Parity block side.
  modport slave (
    input  in_valid, sof, odd_mode, gamma,
    output par_valid, par, frame_valid, frame_par, frame_err, busy
  );
endinterface

// File: rtl/gamma_parity_frame.sv
// Multi-lane gamma parity reducer: per-sample lane parity plus per-frame
// accumulated parity with early-sof abort detection.
module gamma_parity_frame #(
  parameter int unsigned W         = 16,
  parameter int unsigned LANES     = 2,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  gamma_parity_frame_if.slave bus
);

  localparam int unsigned      CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LANES-1:0] acc_q;
  logic [LANES-1:0] acc_d;
  logic             mode_q;
  logic [LANES-1:0] samp_par_c;
  logic             par_valid_q;
  logic [LANES-1:0] par_q;
  logic             frame_valid_q;
  logic [LANES-1:0] frame_par_q;
  logic             frame_err_q;
  logic             busy_q;

  // Reduction XOR of each lane's raw two's-complement bits.
  always_comb begin
    samp_par_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      samp_par_c[k] = ^bus.gamma[k*W +: W];
    end
  end

  // Running frame parity including the current sample.
  always_comb begin
    acc_d = acc_q ^ samp_par_c;
  end

  // Sample path: parity register updates only on valid samples, independent of FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_valid_q <= 1'b0;
      par_q       <= '0;
    end else begin
      par_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        par_q <= samp_par_c;
      end
    end
  end

  // Frame FSM: accumulates lane parities, flags completion or early-sof abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      mode_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_par_q   <= '0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid && bus.sof) begin
            acc_q   <= samp_par_c;
            cnt_q   <= ONE;
            mode_q  <= bus.odd_mode;
            state_q <= ACC;
            busy_q  <= 1'b1;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            if (bus.sof) begin
              // Early sof aborts the open frame and restarts with this sample.
              frame_err_q <= 1'b1;
              acc_q       <= samp_par_c;
              cnt_q       <= ONE;
              mode_q      <= bus.odd_mode;
            end else if (cnt_q == LAST) begin
              frame_valid_q <= 1'b1;
              frame_par_q   <= acc_d ^ {LANES{mode_q}};
              cnt_q         <= '0;
              state_q       <= IDLE;
              busy_q        <= 1'b0;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + ONE;
            end
          end
        end
      endcase
    end
  end

  assign bus.par_valid   = par_valid_q;
  assign bus.par         = par_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_par   = frame_par_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_gamma_parity_frame.sv
// Directed bench for gamma_parity_frame with W=16, LANES=2, FRAME_LEN=4.
module tb_gamma_parity_frame;

  localparam int unsigned W         = 16;
  localparam int unsigned LANES     = 2;
  localparam int unsigned FRAME_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   last_fv = 0;
  int   prev_fv = 0;

  // Lane0 parities 1,0,1,0 ; lane1 parities 1,0,0,0.
  logic [15:0] g0 [4] = '{16'h0001, 16'h0003, 16'h0007, 16'h0000};
  logic [15:0] g1 [4] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000};
  logic [1:0]  ep [4] = '{2'b11, 2'b00, 2'b01, 2'b00};

  gamma_parity_frame_if #(.W(W), .LANES(LANES)) bus ();

  gamma_parity_frame #(.W(W), .LANES(LANES), .FRAME_LEN(FRAME_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic s, input logic o, input logic [31:0] g);
    bus.in_valid = v;
    bus.sof      = s;
    bus.odd_mode = o;
    bus.gamma    = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One FRAME_LEN frame from the vector table, optional gap after sample 1.
  task automatic run_frame(input logic odd, input int gap, input logic err_first,
                           input logic [1:0] exp_fp);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, odd, {g1[i], g0[i]});
      step();
      chk("smp_par", 32'(bus.par), 32'(ep[i]));
      chk("smp_pv", 32'(bus.par_valid), 32'd1);
      chk("frm_err", 32'(bus.frame_err), (i == 0) ? 32'(err_first) : 32'd0);
      chk("frm_fv", 32'(bus.frame_valid), (i == 3) ? 32'd1 : 32'd0);
      chk("frm_busy", 32'(bus.busy), (i == 3) ? 32'd0 : 32'd1);
      if (i == 3) begin
        chk("frm_par", 32'(bus.frame_par), 32'(exp_fp));
        prev_fv = last_fv;
        last_fv = cyc;
      end
      if (i == 1) begin
        for (int j = 0; j < gap; j++) begin
          drive(1'b0, 1'b1, 1'b1, 32'($urandom));
          step();
          chk("gap_busy", 32'(bus.busy), 32'd1);
          chk("gap_fv", 32'(bus.frame_valid), 32'd0);
          chk("gap_pv", 32'(bus.par_valid), 32'd0);
        end
      end
    end
  endtask

  task automatic idle_check(input logic [1:0] held_fp);
    drive(1'b0, 1'b0, 1'b0, 32'($urandom));
    step();
    chk("idle_fv", 32'(bus.frame_valid), 32'd0);
    chk("idle_fp", 32'(bus.frame_par), 32'(held_fp));
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    // 1: reset with random activity on the inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 32'($urandom));
      step();
    end
    chk("rst_pv", 32'(bus.par_valid), 32'd0);
    chk("rst_par", 32'(bus.par), 32'd0);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_fp", 32'(bus.frame_par), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();

    // 2: sample parity and hold
    drive(1'b1, 1'b0, 1'b0, {16'h0001, 16'h0003});
    step();
    chk("sp_par", 32'(bus.par), 32'h2);
    chk("sp_pv", 32'(bus.par_valid), 32'd1);
    chk("sp_busy", 32'(bus.busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'($urandom));
    step();
    chk("hold_pv", 32'(bus.par_valid), 32'd0);
    chk("hold_par", 32'(bus.par), 32'h2);

    // 3: full frames, even then odd mode
    run_frame(1'b0, 0, 1'b0, 2'b10);
    idle_check(2'b10);
    run_frame(1'b1, 0, 1'b0, 2'b01);
    idle_check(2'b01);

    // 4: gap of 5 idle cycles mid-frame
    run_frame(1'b0, 5, 1'b0, 2'b10);
    idle_check(2'b10);

    // 5: early sof after two samples of an odd-mode frame
    drive(1'b1, 1'b1, 1'b1, {g1[0], g0[0]});
    step();
    chk("es_busy0", 32'(bus.busy), 32'd1);
    drive(1'b1, 1'b0, 1'b1, {g1[1], g0[1]});
    step();
    chk("es_err1", 32'(bus.frame_err), 32'd0);
    run_frame(1'b0, 0, 1'b1, 2'b10);
    idle_check(2'b10);

    // 6a: back-to-back frames, pulses 4 cycles apart
    run_frame(1'b0, 0, 1'b0, 2'b10);
    run_frame(1'b1, 0, 1'b0, 2'b01);
    chk("b2b_gap", 32'(last_fv - prev_fv), 32'd4);
    idle_check(2'b01);

    // 6b: reset mid-frame, sof coincident with rst ignored
    drive(1'b1, 1'b1, 1'b0, {g1[0], g0[0]});
    step();
    drive(1'b1, 1'b0, 1'b0, {g1[1], g0[1]});
    step();
    chk("mr_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, {g1[2], g0[2]});
    step();
    rst = 1'b0;
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_err", 32'(bus.frame_err), 32'd0);
    chk("mr_fv", 32'(bus.frame_valid), 32'd0);
    chk("mr_fp", 32'(bus.frame_par), 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, {g1[2 + i], g0[2 + i]});
      step();
      chk("mr_post_busy", 32'(bus.busy), 32'd0);
      chk("mr_post_fv", 32'(bus.frame_valid), 32'd0);
      chk("mr_post_err", 32'(bus.frame_err), 32'd0);
      chk("mr_post_par", 32'(bus.par), 32'(ep[2 + i]));
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("mr_end_fv", 32'(bus.frame_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
